// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared encodings and helpers for the pipeline hazard/stall
//               control slice (FSM states, register-zero, NOP word).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Front-end controller states
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    MD_BUSY = 2'd2
  } ctrl_state_e;

  // $zero never carries a real dependency
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Word loaded into IF/ID on a flush; also the canonical pipeline NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // True when a producer destination is a live (non-$zero) match of a source
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational decode of the ID-stage stall condition:
//               load-use dependency or MULT/DIV unit occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       id_md_start_i,
  input  logic       id_md_use_i,
  input  logic       id_ex_mem_read_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic       md_active_i,
  output logic       id_stall_o
);

  logic load_use;
  logic md_haz;

  // Load-use needs the load result one cycle too early; MD ops/reads must wait for the unit
  always_comb begin
    load_use   = id_ex_mem_read_i &&
                 (reg_hit(id_ex_rt_i, id_rs_i) ||
                  (id_uses_rt_i && reg_hit(id_ex_rt_i, id_rt_i)));
    md_haz     = md_active_i && (id_md_start_i || id_md_use_i);
    id_stall_o = load_use || md_haz;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Central hazard/stall controller for the 5-stage pipeline.
//               Drives PC enable, IF/ID load/flush and ID/EX bubble, tracks
//               MULT/DIV occupancy and keeps saturating stall/flush counts.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY   = 4,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_reg_ctrl,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0]       MD_LOAD   = 4'(MD_LATENCY - 1);
  localparam logic [2:0]       HOLD_LOAD = 3'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [2:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             id_stall;
  logic             md_issue;
  logic             active;

  hazard_detect u_hazard_detect (
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .id_uses_rt_i     (id_uses_rt),
    .id_md_start_i    (id_md_start),
    .id_md_use_i      (id_md_use),
    .id_ex_mem_read_i (id_ex_mem_read),
    .id_ex_rt_i       (id_ex_rt),
    .md_active_i      (md_cnt_q != 4'd0),
    .id_stall_o       (id_stall)
  );

  // Hazard decode only matters once the front end has left HOLD
  assign active = (state_q == RUN) || (state_q == MD_BUSY);

  // Next-state, MD countdown and pipeline control outputs (branch > stall > imem wait)
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    md_cnt_d       = md_cnt_q;
    md_issue       = 1'b0;
    pc_write       = 1'b0;
    if_id_reg_ctrl = 1'b1;
    if_id_flush    = 1'b1;
    id_ex_bubble   = 1'b1;

    case (state_q)
      HOLD: begin
        if (hold_cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 3'd1;
        end
      end

      RUN, MD_BUSY: begin
        if (ex_branch_taken) begin
          pc_write       = 1'b1;
          if_id_reg_ctrl = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_bubble   = 1'b1;
        end else if (id_stall) begin
          // IF/ID holds its contents, so no flush even if fetch is also stalled
          pc_write       = 1'b0;
          if_id_reg_ctrl = 1'b0;
          if_id_flush    = 1'b0;
          id_ex_bubble   = 1'b1;
        end else if (!imem_ready) begin
          pc_write       = 1'b0;
          if_id_reg_ctrl = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_bubble   = 1'b0;
        end else begin
          pc_write       = 1'b1;
          if_id_reg_ctrl = 1'b1;
          if_id_flush    = 1'b0;
          id_ex_bubble   = 1'b0;
        end

        // A squashed or stalled MD instruction does not reach the unit
        md_issue = id_md_start && !ex_branch_taken && !id_stall;

        // Countdown keeps running through flushes and fetch waits
        if (md_issue) begin
          md_cnt_d = MD_LOAD;
          state_d  = (MD_LOAD != 4'd0) ? MD_BUSY : RUN;
        end else if (md_cnt_q != 4'd0) begin
          md_cnt_d = md_cnt_q - 4'd1;
          state_d  = (md_cnt_q == 4'd1) ? RUN : MD_BUSY;
        end else begin
          state_d  = RUN;
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // Saturating performance counters; a branch flush pre-empts a stall in the same cycle
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (active) begin
      if (ex_branch_taken) begin
        flush_d = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_ONE;
      end else if (id_stall) begin
        stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_ONE;
      end
    end
  end

  // State, countdowns and counters; reset discards any MD operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= HOLD_LOAD;
      md_cnt_q   <= 4'd0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      md_cnt_q   <= md_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign md_busy      = active && (md_cnt_q != 4'd0);
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. Two instances
//               (default parameters, and MD_LATENCY=1/RESET_CYCLES=3/CNT_W=3)
//               share stimulus; a timestamp-based reference model checks
//               every cycle, and directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rt, id_md_start, id_md_use, id_ex_mem_read;
  logic       ex_branch_taken, imem_ready;

  logic        pc0, ifid0, fl0, bub0, busy0;
  logic [15:0] stall0, flcnt0;
  logic        pc1, ifid1, fl1, bub1, busy1;
  logic [2:0]  stall1, flcnt1;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_stall_ctrl #(.MD_LATENCY(4), .RESET_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_use(id_md_use), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_write(pc0), .if_id_reg_ctrl(ifid0), .if_id_flush(fl0), .id_ex_bubble(bub0),
    .md_busy(busy0), .stall_cycles(stall0), .flush_count(flcnt0)
  );

  hazard_stall_ctrl #(.MD_LATENCY(1), .RESET_CYCLES(3), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_use(id_md_use), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_write(pc1), .if_id_reg_ctrl(ifid1), .if_id_flush(fl1), .id_ex_bubble(bub1),
    .md_busy(busy1), .stall_cycles(stall1), .flush_count(flcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d] got %0d expected %0d at %0t", nm, inst, act, exp, $time);
  endtask

  // ---------------- reference model (timestamps, plain integers) -----------
  int     p_lat[2]  = '{4, 1};
  int     p_rst[2]  = '{2, 3};
  int     p_w[2]    = '{16, 3};
  bit     m_valid[2];
  longint hold_until[2];   // cycles k < hold_until are front-end hold
  longint md_free[2];      // cycles k < md_free have the MD unit busy
  longint n_stall[2];
  longint n_flush[2];
  longint k = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit in_hold, busy, lu, stall;
      longint maxv;
      logic e_pc, e_ifid, e_fl, e_bub;
      logic a_pc, a_ifid, a_fl, a_bub, a_busy;
      logic [15:0] a_st, a_fc;
      in_hold = (k < hold_until[i]);
      busy    = !in_hold && (k < md_free[i]);
      lu      = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
      stall   = lu || (busy && (id_md_start || id_md_use));
      maxv    = (64'd1 << p_w[i]) - 1;
      if (in_hold)              {e_pc, e_ifid, e_fl, e_bub} = 4'b0111;
      else if (ex_branch_taken) {e_pc, e_ifid, e_fl, e_bub} = 4'b1111;
      else if (stall)           {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      else if (!imem_ready)     {e_pc, e_ifid, e_fl, e_bub} = 4'b0110;
      else                      {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
      if (i == 0) {a_pc, a_ifid, a_fl, a_bub, a_busy, a_st, a_fc} = {pc0, ifid0, fl0, bub0, busy0, stall0, flcnt0};
      else        {a_pc, a_ifid, a_fl, a_bub, a_busy, a_st, a_fc} = {pc1, ifid1, fl1, bub1, busy1, 13'd0, stall1, 13'd0, flcnt1};
      if (m_valid[i]) begin
        chk("pc_write", i, 64'(a_pc), 64'(e_pc));
        chk("if_id_reg_ctrl", i, 64'(a_ifid), 64'(e_ifid));
        chk("if_id_flush", i, 64'(a_fl), 64'(e_fl));
        chk("id_ex_bubble", i, 64'(a_bub), 64'(e_bub));
        chk("md_busy", i, 64'(a_busy), 64'(busy));
        chk("stall_cycles", i, 64'(a_st), (n_stall[i] > maxv) ? maxv : n_stall[i]);
        chk("flush_count", i, 64'(a_fc), (n_flush[i] > maxv) ? maxv : n_flush[i]);
      end
      // advance model to the next cycle
      if (!rst_n) begin
        m_valid[i]    = 1'b1;
        hold_until[i] = k + 1 + p_rst[i];
        md_free[i]    = 0;
        n_stall[i]    = 0;
        n_flush[i]    = 0;
      end else if (m_valid[i] && !in_hold) begin
        if (ex_branch_taken) n_flush[i]++;
        else if (stall)      n_stall[i]++;
        if (id_md_start && !ex_branch_taken && !stall) md_free[i] = k + p_lat[i];
      end
    end
    k++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_ex_rt = 5'd0; id_uses_rt = 1'b0;
    id_md_start = 1'b0; id_md_use = 1'b0; id_ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic lu_inputs(input logic [4:0] r);
    id_ex_mem_read = 1'b1; id_ex_rt = r; id_rs = r;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    // reset hold: two cycles of PC frozen and IF/ID flushed
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("lit_hold_pc", 0, 64'(pc0), 64'd0);
      chk("lit_hold_flush", 0, 64'(fl0), 64'd1);
      cyc();
    end
    @(negedge clk);
    chk("lit_run_pc", 0, 64'(pc0), 64'd1);
    chk("lit_run_ifid", 0, 64'(ifid0), 64'd1);
    chk("lit_run_stall", 0, 64'(stall0), 64'd0);
    chk("lit_run_flcnt", 0, 64'(flcnt0), 64'd0);

    // load-use on r8
    cyc(); lu_inputs(5'd8);
    @(negedge clk);
    chk("lit_lu_pc", 0, 64'(pc0), 64'd0);
    chk("lit_lu_ifid", 0, 64'(ifid0), 64'd0);
    chk("lit_lu_bub", 0, 64'(bub0), 64'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lit_lu_cnt", 0, 64'(stall0), 64'd1);
    // load into $zero is never a dependency
    cyc(); lu_inputs(5'd0);
    @(negedge clk);
    chk("lit_lu0_pc", 0, 64'(pc0), 64'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lit_lu0_cnt", 0, 64'(stall0), 64'd1);

    // MULT then MFHI held
    cyc(); id_md_start = 1'b1;
    @(negedge clk);
    chk("lit_mult_pc", 0, 64'(pc0), 64'd1);
    chk("lit_mult_busy", 0, 64'(busy0), 64'd0);
    cyc(); id_md_start = 1'b0; id_md_use = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("lit_mfhi_busy", 0, 64'(busy0), 64'd1);
      chk("lit_mfhi_ifid", 0, 64'(ifid0), 64'd0);
      cyc();
    end
    @(negedge clk);
    chk("lit_mfhi_done_busy", 0, 64'(busy0), 64'd0);
    chk("lit_mfhi_done_ifid", 0, 64'(ifid0), 64'd1);
    chk("lit_mfhi_done_cnt", 0, 64'(stall0), 64'd4);
    cyc(); idle();

    // branch taken together with load-use: flush only
    ex_branch_taken = 1'b1; lu_inputs(5'd8);
    @(negedge clk);
    chk("lit_br_flush", 0, 64'(fl0), 64'd1);
    chk("lit_br_bub", 0, 64'(bub0), 64'd1);
    chk("lit_br_pc", 0, 64'(pc0), 64'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lit_br_flcnt", 0, 64'(flcnt0), 64'd1);
    chk("lit_br_stall", 0, 64'(stall0), 64'd4);

    // imem wait while the MD unit counts down
    cyc(); id_md_start = 1'b1;
    cyc(); id_md_start = 1'b0; imem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("lit_imem_pc", 0, 64'(pc0), 64'd0);
      chk("lit_imem_flush", 0, 64'(fl0), 64'd1);
      chk("lit_imem_bub", 0, 64'(bub0), 64'd0);
      chk("lit_imem_busy", 0, 64'(busy0), 64'd1);
      cyc();
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("lit_imem_done_busy", 0, 64'(busy0), 64'd0);

    // reset while md count is 2
    cyc(); id_md_start = 1'b1;
    cyc(); id_md_start = 1'b0;
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("lit_prerst_busy", 0, 64'(busy0), 64'd1);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_busy", 0, 64'(busy0), 64'd0);
    chk("lit_rst_pc", 0, 64'(pc0), 64'd0);
    chk("lit_rst_flush", 0, 64'(fl0), 64'd1);
    chk("lit_rst_stall", 0, 64'(stall0), 64'd0);
    cyc(); cyc(); cyc();

    // saturation: 9 stalls into a 3-bit counter
    lu_inputs(5'd3);
    for (int j = 0; j < 9; j++) cyc();
    idle();
    @(negedge clk);
    chk("lit_sat_stall1", 1, 64'(stall1), 64'd7);
    chk("lit_sat_stall0", 0, 64'(stall0), 64'd9);

    // randomized traffic
    for (int j = 0; j < 4000; j++) begin
      cyc();
      rst_n           = ($urandom_range(0, 99) >= 2);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_ex_rt        = 5'($urandom_range(0, 3));
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      id_ex_mem_read  = ($urandom_range(0, 99) < 30);
      id_md_start     = ($urandom_range(0, 99) < 15);
      id_md_use       = ($urandom_range(0, 99) < 15);
      ex_branch_taken = ($urandom_range(0, 99) < 12);
      imem_ready      = ($urandom_range(0, 99) < 80);
    end
    cyc(); idle(); rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the PC write enable, the IF_ID_SB load control (if_id_reg_ctrl) and flush, and the ID/EX bubble insert.
- Handles three hazard classes: load-use, multi-cycle MULT/DIV occupancy, and taken-branch squash. It also inserts fetch bubbles while instruction memory is not ready, and keeps saturating stall/flush statistics.

Parameters:
- MD_LATENCY, 4, cycles the MULT/DIV unit stays busy after issue (legal range 1..15).
- RESET_CYCLES, 2, cycles the front end is held after reset deassertion (legal range 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_md_start  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
- id_md_use  input  1  ID instruction is MFHI/MFLO.
- id_ex_mem_read  input  1  instruction in EX is a load.
- id_ex_rt  input  5  destination register of the instruction in EX.
- ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- imem_ready  input  1  fetch data valid this cycle.
- pc_write  output  1  PC register load enable.
- if_id_reg_ctrl  output  1  IF_ID_SB load enable (1 = capture, 0 = hold).
- if_id_flush  output  1  IF_ID_SB loads NOP instead of the fetched word.
- id_ex_bubble  output  1  ID/EX loads zero control (NOP).
- md_busy  output  1  MULT/DIV countdown nonzero.
- stall_cycles  output  CNT_W  cycles with id stall asserted, saturating.
- flush_count  output  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- State machine: HOLD, RUN, MD_BUSY. The state register and counters are registered. Control outputs are combinational from state and inputs (zero latency).
- Reset (rst_n=0 at an edge):
  - state becomes HOLD, hold_cnt becomes RESET_CYCLES-1, md_cnt becomes 0.
  - stall_cycles and flush_count become 0. This overrides any operation in flight, including a nonzero md_cnt.
- HOLD outputs: pc_write=0, if_id_reg_ctrl=1, if_id_flush=1, id_ex_bubble=1, md_busy=0.
  - hold_cnt decrements each cycle. At 0 the next state is RUN.
  - All hazard inputs are ignored.
- Hazard terms, evaluated in RUN and MD_BUSY:
  - load_use = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==id_rs || (id_uses_rt && id_ex_rt==id_rt)).
  - md_haz = md_cnt!=0 && (id_md_start || id_md_use).
  - id_stall = load_use || md_haz.
- Priority of cycle actions, highest first:
  1. ex_branch_taken: pc_write=1, if_id_reg_ctrl=1, if_id_flush=1, id_ex_bubble=1. The ID instruction is squashed, so no MD issue occurs. flush_count increments.
  2. id_stall: pc_write=0, if_id_reg_ctrl=0, if_id_flush=0, id_ex_bubble=1. stall_cycles increments.
  3. !imem_ready: pc_write=0, if_id_reg_ctrl=1, if_id_flush=1, id_ex_bubble=0. The ID instruction proceeds.
  4. Otherwise: pc_write=1, if_id_reg_ctrl=1, if_id_flush=0, id_ex_bubble=0.
- MD issue = id_md_start && !ex_branch_taken && !id_stall, in RUN or MD_BUSY.
  - On issue, md_cnt loads MD_LATENCY-1. If that value is nonzero, the next state is MD_BUSY; otherwise it is RUN.
  - If there is no issue and md_cnt!=0, md_cnt decrements. When it reaches 0, the next state is RUN.
  - md_busy = (md_cnt!=0).
  - The countdown continues during branch flushes and imem waits.
- With MD_LATENCY=1, MD_BUSY is never entered and md_haz is never true.
- Simultaneous events:
  - A branch taken together with load_use gives a flush only; no stall is counted.
  - load_use together with !imem_ready gives a stall. if_id_flush stays 0 because IF/ID holds its contents.
- Counters saturate at all-ones and never wrap. Each increments by at most 1 per cycle.
- md_cnt width is 4 bits.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding: HOLD=2'd0, RUN=2'd1, MD_BUSY=2'd2;
  - REG_ZERO=5'd0;
  - the NOP instruction constant 32'h0000_0000, also used by IF_ID_SB flush.
- One natural sub-module: hazard_detect, the purely combinational load_use/md_haz/id_stall decode. The FSM, countdown and perf counters stay in hazard_stall_ctrl.

Test Plan:
- Reset and hold: rst_n=0 for 2 cycles, then 1. Required: pc_write=0 and if_id_flush=1 for exactly 2 cycles (RESET_CYCLES=2), then pc_write=1 and if_id_reg_ctrl=1, with both counters equal to 0.
- Load-use: id_ex_mem_read=1, id_ex_rt=5'd8, id_rs=5'd8 for one cycle. Required: pc_write=0, if_id_reg_ctrl=0, id_ex_bubble=1, stall_cycles=1. A repeat with id_ex_rt=0 must give no stall.
- MULT then MFHI: id_md_start=1 for 1 cycle, then id_md_use=1 held. Required: md_busy high for 3 cycles (MD_LATENCY=4), 3 stall cycles, then if_id_reg_ctrl=1 and stall_cycles=3.
- Branch with simultaneous load_use: ex_branch_taken=1 with load_use true. Required: if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_count=1, stall_cycles unchanged.
- imem wait: imem_ready=0 for 3 cycles. Required: pc_write=0, if_id_flush=1, id_ex_bubble=0 in each cycle, and md_cnt keeps decrementing if busy.
- Reset mid-MD_BUSY and saturation: assert rst_n=0 while md_cnt=2. Required: md_busy=0 and state HOLD on the next edge. Separately, preload 16'hFFFF in stall_cycles, stall once, and check it stays 16'hFFFF.
